// File: rtl/dw_sum_pkg.sv
// Shared elaboration-time helpers for the dw_sum_pipe adder tree.
//   clog2       : ceiling log2, returns 0 for an argument of 0 or 1
//   tree_w      : adder-tree width that can hold the sum of n lanes
//   level_cnt   : operand count entering tree level lvl
//   level_reg   : whether tree level lvl carries a pipeline register
//   max_val/min_val : OUT range limits, 64-bit two's complement, w in 1..62
package dw_sum_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned tree_w(input int unsigned in_w, input int unsigned n);
    return in_w + clog2(n);
  endfunction

  function automatic int unsigned level_cnt(input int unsigned n, input int unsigned lvl);
    int unsigned c;
    c = n;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < lvl) c = (c + 1) / 2;
    end
    return c;
  endfunction

  // Spread nregs registers over levels; a level is registered where the running share
  // floor((lvl+1)*nregs/levels) steps up, which favours later levels when uneven.
  function automatic bit level_reg(input int unsigned levels, input int unsigned nregs,
                                   input int unsigned lvl);
    if (levels == 0) return 1'b0;
    return ((lvl + 1) * nregs / levels) > (lvl * nregs / levels);
  endfunction

  function automatic logic [63:0] max_val(input bit tc, input int unsigned w);
    if (tc) return (64'd1 << (w - 1)) - 64'd1;
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] min_val(input bit tc, input int unsigned w);
    if (tc) return 64'd0 - (64'd1 << (w - 1));
    return 64'd0;
  endfunction

endpackage

// File: rtl/dw_sum_tree_level.sv
// One pairwise-add level of the dw_sum_pipe adder tree.
//   clk, rst_n          : clock / async active-low reset (used only when REG=1)
//   en                  : pipeline advance
//   in_valid, in_last   : sideband travelling with the operands
//   in_bus              : NUM_LANES lanes of LANE_W bits, only the low IN_CNT lanes are live
//   out_valid, out_last : sideband after this level
//   out_bus             : ceil(IN_CNT/2) live lanes, unused upper lanes are zero
module dw_sum_tree_level #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned IN_CNT    = 4,
  parameter int unsigned LANE_W    = 10,
  parameter bit          REG       = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        in_valid,
  input  logic                        in_last,
  input  logic [NUM_LANES*LANE_W-1:0] in_bus,
  output logic                        out_valid,
  output logic                        out_last,
  output logic [NUM_LANES*LANE_W-1:0] out_bus
);

  localparam int unsigned OutCnt = (IN_CNT + 1) / 2;

  logic [NUM_LANES*LANE_W-1:0] sum;

  // Width is sized for the whole tree, so a pair sum never overflows a lane.
  always_comb begin
    sum = '0;
    for (int unsigned j = 0; j < OutCnt; j++) begin
      if (2 * j + 1 < IN_CNT) begin
        sum[j*LANE_W +: LANE_W] = in_bus[2*j*LANE_W +: LANE_W] +
                                  in_bus[(2*j+1)*LANE_W +: LANE_W];
      end else begin
        sum[j*LANE_W +: LANE_W] = in_bus[2*j*LANE_W +: LANE_W];
      end
    end
  end

  if (REG) begin : g_reg
    logic                        valid_q;
    logic                        last_q;
    logic [NUM_LANES*LANE_W-1:0] bus_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        bus_q   <= '0;
      end else if (en) begin
        valid_q <= in_valid;
        last_q  <= in_last;
        bus_q   <= sum;
      end
    end

    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_bus   = bus_q;
  end else begin : g_comb
    assign out_valid = in_valid;
    assign out_last  = in_last;
    assign out_bus   = sum;
  end

endmodule

// File: rtl/dw_sum_pipe.sv
// Pipelined multi-operand adder with valid/ready on both sides.
//   clk, rst_n            : clock / async active-low reset
//   in_valid, in_ready    : input handshake, in_ready is the pipeline enable
//   in_data, in_mask      : NUM_INPUTS lanes of IN_WIDTH bits, mask bit 0 zeroes a lane
//   in_last               : closes an accumulation group (ACC_MODE=1 only)
//   out_valid, out_ready  : output handshake, outputs hold while stalled
//   out_sum, out_ovf      : wrapped/clamped result and overflow flag (sticky over a group)
// OUT_WIDTH is limited to 62 bits by the 64-bit range helpers.
module dw_sum_pipe
  import dw_sum_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned OUT_WIDTH  = IN_WIDTH + clog2(NUM_INPUTS),
  parameter int unsigned STAGES     = 2,
  parameter int unsigned TC_MODE    = 0,
  parameter int unsigned SAT_MODE   = 0,
  parameter int unsigned ACC_MODE   = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_INPUTS*IN_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]          in_mask,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_WIDTH-1:0]           out_sum,
  output logic                           out_ovf
);

  localparam int unsigned Levels = clog2(NUM_INPUTS);
  localparam int unsigned TreeW  = tree_w(IN_WIDTH, NUM_INPUTS);
  // Headroom for range checks and for acc + converted sum at OUT_WIDTH+1 bits.
  localparam int unsigned ExtW   = ((TreeW > OUT_WIDTH + 1) ? TreeW : OUT_WIDTH + 1) + 1;
  localparam logic [63:0] Max64  = max_val(TC_MODE != 0, OUT_WIDTH);
  localparam logic [63:0] Min64  = min_val(TC_MODE != 0, OUT_WIDTH);
  localparam logic signed [ExtW-1:0] MaxV = $signed(Max64[ExtW-1:0]);
  localparam logic signed [ExtW-1:0] MinV = $signed(Min64[ExtW-1:0]);

  typedef struct packed {
    logic                 ovf;
    logic [OUT_WIDTH-1:0] res;
  } fit_t;

  function automatic logic signed [ExtW-1:0] ext_tree(input logic [TreeW-1:0] v);
    if (TC_MODE != 0) return ExtW'($signed(v));
    return ExtW'(v);
  endfunction

  function automatic logic signed [ExtW-1:0] ext_out(input logic [OUT_WIDTH-1:0] v);
    if (TC_MODE != 0) return ExtW'($signed(v));
    return ExtW'(v);
  endfunction

  // Range check against the OUT_WIDTH limits, then clamp or keep the low bits.
  function automatic fit_t fit(input logic signed [ExtW-1:0] v);
    fit_t f;
    logic hi;
    logic lo;
    hi    = v > MaxV;
    lo    = v < MinV;
    f.ovf = hi | lo;
    f.res = v[OUT_WIDTH-1:0];
    if (SAT_MODE != 0) begin
      if (hi) f.res = MaxV[OUT_WIDTH-1:0];
      else if (lo) f.res = MinV[OUT_WIDTH-1:0];
    end
    return f;
  endfunction

  logic en;
  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  // Lane masking and extension to tree width.
  logic [NUM_INPUTS*TreeW-1:0] lane_bus;
  always_comb begin
    logic [IN_WIDTH-1:0] lane;
    lane_bus = '0;
    lane     = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      lane = in_mask[k] ? in_data[k*IN_WIDTH +: IN_WIDTH] : '0;
      if (TC_MODE != 0) lane_bus[k*TreeW +: TreeW] = TreeW'($signed(lane));
      else              lane_bus[k*TreeW +: TreeW] = TreeW'(lane);
    end
  end

  logic [NUM_INPUTS*TreeW-1:0] lvl_bus   [Levels+1];
  logic                        lvl_valid [Levels+1];
  logic                        lvl_last  [Levels+1];

  assign lvl_bus[0]   = lane_bus;
  assign lvl_valid[0] = in_valid;
  assign lvl_last[0]  = in_last;

  for (genvar l = 0; l < Levels; l++) begin : g_lvl
    dw_sum_tree_level #(
      .NUM_LANES (NUM_INPUTS),
      .IN_CNT    (level_cnt(NUM_INPUTS, l)),
      .LANE_W    (TreeW),
      .REG       (level_reg(Levels, STAGES - 1, l))
    ) u_level (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_valid  (lvl_valid[l]),
      .in_last   (lvl_last[l]),
      .in_bus    (lvl_bus[l]),
      .out_valid (lvl_valid[l+1]),
      .out_last  (lvl_last[l+1]),
      .out_bus   (lvl_bus[l+1])
    );
  end

  logic [TreeW-1:0] tree_sum;
  logic             tree_valid;
  logic             tree_last;
  assign tree_sum   = lvl_bus[Levels][TreeW-1:0];
  assign tree_valid = lvl_valid[Levels];
  assign tree_last  = (ACC_MODE == 0) | lvl_last[Levels];

  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] sum_q, sum_d;
  logic                 ovf_q, ovf_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic                 sticky_q, sticky_d;
  fit_t                 conv;
  fit_t                 acc_fit;
  logic                 beat_ovf;

  always_comb begin
    conv        = fit(ext_tree(tree_sum));
    acc_fit     = fit(ext_out(acc_q) + ext_out(conv.res));
    beat_ovf    = conv.ovf | acc_fit.ovf;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    if (en) begin
      out_valid_d = 1'b0;
      if (tree_valid) begin
        if (ACC_MODE == 0) begin
          out_valid_d = 1'b1;
          sum_d       = conv.res;
          ovf_d       = conv.ovf;
        end else if (tree_last) begin
          out_valid_d = 1'b1;
          sum_d       = acc_fit.res;
          ovf_d       = sticky_q | beat_ovf;
          acc_d       = '0;
          sticky_d    = 1'b0;
        end else begin
          acc_d       = acc_fit.res;
          sticky_d    = sticky_q | beat_ovf;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_dw_sum_pipe.sv
// Scoreboard bench for dw_sum_pipe: four configurations driven side by side.
//   0: N=4 W=8 OUT=10 STAGES=2 unsigned wrap
//   1: N=4 W=8 OUT=8  STAGES=3 two's complement saturate
//   2: N=4 W=8 OUT=8  STAGES=1 two's complement wrap
//   3: N=3 W=8 OUT=10 STAGES=2 unsigned saturate, accumulate
module tb_dw_sum_pipe;

  localparam int NDUT = 4;
  localparam int N_C   [NDUT] = '{4, 4, 4, 3};
  localparam int OW_C  [NDUT] = '{10, 8, 8, 10};
  localparam int ST_C  [NDUT] = '{2, 3, 1, 2};
  localparam int TC_C  [NDUT] = '{0, 1, 1, 0};
  localparam int SAT_C [NDUT] = '{0, 1, 0, 1};
  localparam int ACC_C [NDUT] = '{0, 0, 0, 1};

  typedef struct {
    logic [9:0] sum;
    logic       ovf;
    bit         lat;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid  [NDUT];
  logic       in_ready  [NDUT];
  logic       in_last   [NDUT];
  logic [31:0] in_data  [NDUT];
  logic [3:0] in_mask   [NDUT];
  logic       out_valid [NDUT];
  logic       out_ready [NDUT];
  logic [9:0] out_sum   [NDUT];
  logic       out_ovf   [NDUT];

  int     rdy_mode [NDUT];  // 0 always ready, 1 random, 2 held low
  exp_t   exp_q    [NDUT][$];
  longint m_acc    [NDUT];
  bit     m_sticky [NDUT];
  int     n_cmp;
  int     n_err;
  int     cyc;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int NL = N_C[g];
    logic [OW_C[g]-1:0] s;
    dw_sum_pipe #(
      .NUM_INPUTS (NL),
      .IN_WIDTH   (8),
      .OUT_WIDTH  (OW_C[g]),
      .STAGES     (ST_C[g]),
      .TC_MODE    (TC_C[g]),
      .SAT_MODE   (SAT_C[g]),
      .ACC_MODE   (ACC_C[g])
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g][NL*8-1:0]),
      .in_mask   (in_mask[g][NL-1:0]),
      .in_last   (in_last[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_sum   (s),
      .out_ovf   (out_ovf[g])
    );
    assign out_sum[g] = 10'(s);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  function automatic void chk(input bit ok, input string nm, input longint act,
                              input longint req);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
    end
  endfunction

  // Reference: clip an integer into the OUT_WIDTH range of one configuration.
  function automatic longint fit_v(input int id, input longint v, output bit ovf);
    longint lo, hi, r, md;
    int ow;
    ow  = OW_C[id];
    md  = longint'(1) << ow;
    lo  = (TC_C[id] != 0) ? -(longint'(1) << (ow - 1)) : 0;
    hi  = (TC_C[id] != 0) ? (longint'(1) << (ow - 1)) - 1 : md - 1;
    ovf = (v < lo) || (v > hi);
    if (!ovf) return v;
    if (SAT_C[id] != 0) return (v > hi) ? hi : lo;
    r = v & (md - 1);
    if (r > hi) r = r - md;
    return r;
  endfunction

  function automatic void model_beat(input int id, input logic [31:0] d, input logic [3:0] m,
                                     input bit last, input bit lat, input int c);
    longint s, cv, av;
    bit o1, o2;
    logic [7:0] b;
    exp_t e;
    s = 0;
    for (int k = 0; k < N_C[id]; k++) begin
      b = d[k*8 +: 8];
      if (m[k]) s += (TC_C[id] != 0) ? longint'($signed(b)) : longint'(b);
    end
    cv    = fit_v(id, s, o1);
    e.lat = lat;
    e.cyc = c;
    if (ACC_C[id] == 0) begin
      e.sum = 10'(cv & ((longint'(1) << OW_C[id]) - 1));
      e.ovf = o1;
      exp_q[id].push_back(e);
    end else begin
      av = fit_v(id, m_acc[id] + cv, o2);
      if (last) begin
        e.sum = 10'(av & ((longint'(1) << OW_C[id]) - 1));
        e.ovf = m_sticky[id] | o1 | o2;
        exp_q[id].push_back(e);
        m_acc[id]    = 0;
        m_sticky[id] = 1'b0;
      end else begin
        m_acc[id]    = av;
        m_sticky[id] = m_sticky[id] | o1 | o2;
      end
    end
  endfunction

  function automatic logic [31:0] pack(input int a, input int b, input int c, input int e);
    return {8'(e), 8'(c), 8'(b), 8'(a)};
  endfunction

  // Called at posedge+1; holds the beat until accepted and returns at posedge+1.
  task automatic send(input int id, input logic [31:0] d, input logic [3:0] m, input bit last,
                      input bit track, input bit lat);
    int w;
    w            = 0;
    in_valid[id] = 1'b1;
    in_data[id]  = d;
    in_mask[id]  = m;
    in_last[id]  = last;
    forever begin
      @(negedge clk);
      if (in_ready[id]) break;
      w++;
      if (w > 200) begin
        chk(1'b0, $sformatf("dut%0d accept_timeout", id), 0, 1);
        break;
      end
    end
    if (in_ready[id] && track) model_beat(id, d, m, last, lat, cyc);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int id);
    in_valid[id] = 1'b0;
    in_last[id]  = 1'b0;
  endtask

  task automatic drain(input int id);
    for (int w = 0; w < 500; w++) begin
      if (exp_q[id].size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk(exp_q[id].size() == 0, $sformatf("dut%0d drain", id), exp_q[id].size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_rand(input int id, input int n);
    logic [31:0] d;
    logic [3:0] m;
    bit last;
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 3))
          0:       d[k*8 +: 8] = 8'h00;
          1:       d[k*8 +: 8] = 8'hFF;
          2:       d[k*8 +: 8] = 8'h80;
          default: d[k*8 +: 8] = 8'($urandom);
        endcase
      end
      m    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      last = (ACC_C[id] != 0) ? (($urandom_range(0, 2) == 0) || (j == n - 1)) : 1'b0;
      send(id, d, m, last, 1'b1, 1'b0);
      if ($urandom_range(0, 4) == 0) begin
        idle(id);
        @(posedge clk);
        #1;
      end
    end
    idle(id);
  endtask

  // out_ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NDUT; i++) begin
        case (rdy_mode[i])
          0:       out_ready[i] = 1'b1;
          1:       out_ready[i] = ($urandom_range(0, 2) != 0);
          default: out_ready[i] = 1'b0;
        endcase
      end
    end
  end

  // Monitor: handshake rule, stall hold, and scoreboard pop on every transfer.
  initial begin
    bit         stall [NDUT];
    logic [9:0] hs    [NDUT];
    logic       ho    [NDUT];
    exp_t       e;
    for (int i = 0; i < NDUT; i++) stall[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
        if (!rst_n) begin
          stall[i] = 1'b0;
          continue;
        end
        chk(in_ready[i] == (!out_valid[i] || out_ready[i]), $sformatf("dut%0d in_ready", i),
            in_ready[i], !out_valid[i] || out_ready[i]);
        if (stall[i]) begin
          chk(out_valid[i] && out_sum[i] == hs[i] && out_ovf[i] == ho[i],
              $sformatf("dut%0d hold_sum", i), out_sum[i], hs[i]);
        end
        if (out_valid[i] && out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            chk(1'b0, $sformatf("dut%0d unexpected_output", i), out_sum[i], -1);
          end else begin
            e = exp_q[i].pop_front();
            chk(out_sum[i] == e.sum, $sformatf("dut%0d sum", i), out_sum[i], e.sum);
            chk(out_ovf[i] == e.ovf, $sformatf("dut%0d ovf", i), out_ovf[i], e.ovf);
            if (e.lat) chk(cyc - e.cyc == ST_C[i], $sformatf("dut%0d latency", i),
                           cyc - e.cyc, ST_C[i]);
          end
        end
        stall[i] = out_valid[i] && !out_ready[i];
        hs[i]    = out_sum[i];
        ho[i]    = out_ovf[i];
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      in_valid[i]  = 1'b0;
      in_last[i]   = 1'b0;
      in_data[i]   = '0;
      in_mask[i]   = '0;
      out_ready[i] = 1'b1;
      rdy_mode[i]  = 0;
      m_acc[i]     = 0;
      m_sticky[i]  = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk(out_valid[i] == 1'b0, $sformatf("dut%0d reset_valid", i), out_valid[i], 0);
      chk(out_sum[i] == 10'd0, $sformatf("dut%0d reset_sum", i), out_sum[i], 0);
      chk(out_ovf[i] == 1'b0, $sformatf("dut%0d reset_ovf", i), out_ovf[i], 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic sum with latency, lane mask, all-zero mask.
    send(0, pack(1, 2, 3, 4), 4'hF, 1'b0, 1'b1, 1'b1);
    idle(0);
    drain(0);
    send(0, pack(10, 20, 30, 40), 4'b0101, 1'b0, 1'b1, 1'b0);
    send(0, pack(10, 20, 30, 40), 4'b0000, 1'b0, 1'b1, 1'b0);
    idle(0);
    drain(0);

    // Two's complement extremes, saturate and wrap.
    for (int i = 1; i <= 2; i++) begin
      send(i, pack(8'h7F, 8'h7F, 8'h7F, 8'h7F), 4'hF, 1'b0, 1'b1, 1'b1);
      idle(i);
      drain(i);
      send(i, pack(8'h80, 8'h80, 8'h80, 8'h80), 4'hF, 1'b0, 1'b1, 1'b0);
      idle(i);
      drain(i);
    end

    // Accumulation: 5+6+7 then a single-beat group of 9.
    send(3, pack(2, 3, 0, 0), 4'hF, 1'b0, 1'b1, 1'b0);
    send(3, pack(1, 2, 3, 0), 4'hF, 1'b0, 1'b1, 1'b0);
    send(3, pack(7, 0, 0, 0), 4'hF, 1'b1, 1'b1, 1'b1);
    idle(3);
    drain(3);
    send(3, pack(4, 4, 1, 0), 4'hF, 1'b1, 1'b1, 1'b1);
    idle(3);
    drain(3);

    // Back-to-back stream with out_ready held low for three cycles mid-stream.
    fork
      begin
        for (int j = 0; j < 8; j++) send(0, $urandom, 4'hF, 1'b0, 1'b1, 1'b0);
        idle(0);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rdy_mode[0] = 2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rdy_mode[0] = 0;
      end
    join
    drain(0);

    // Randomized traffic with random backpressure on all configurations.
    for (int i = 0; i < NDUT; i++) rdy_mode[i] = 1;
    fork
      run_rand(0, 60);
      run_rand(1, 60);
      run_rand(2, 60);
      run_rand(3, 80);
    join
    for (int i = 0; i < NDUT; i++) rdy_mode[i] = 0;
    for (int i = 0; i < NDUT; i++) drain(i);

    // Reset with beats in flight and a partial group: nothing may come out.
    send(3, pack(50, 50, 50, 0), 4'hF, 1'b0, 1'b0, 1'b0);
    send(3, pack(60, 60, 60, 0), 4'hF, 1'b0, 1'b0, 1'b0);
    send(3, pack(70, 70, 70, 0), 4'hF, 1'b0, 1'b0, 1'b0);
    send(3, pack(80, 80, 80, 0), 4'hF, 1'b1, 1'b0, 1'b0);
    idle(3);
    rst_n       = 1'b0;
    m_acc[3]    = 0;
    m_sticky[3] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      chk(out_valid[i] == 1'b0, $sformatf("dut%0d midreset_valid", i), out_valid[i], 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send(3, pack(3, 3, 3, 0), 4'hF, 1'b0, 1'b1, 1'b0);
    send(3, pack(1, 1, 2, 0), 4'hF, 1'b1, 1'b1, 1'b1);
    idle(3);
    drain(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
